muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clock  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_data  input  32  operand A, taken from register-file rdata1.
REQ-007 rs2_data  input  32  operand B, taken from register-file rdata2.
REQ-008 rd_addr  input  5  destination register.
REQ-009 busy  output  1  high in MUL, DIV and DONE states.
REQ-010 done  output  1  one-cycle pulse; result is valid.
REQ-011 result  output  32  operation result.
REQ-012 wb_addr  output  5  captured rd_addr, drives register-file waddr.
REQ-013 wb_en  output  1  equals done AND (wb_addr != 0), drives register-file reg_wr.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE; IDLE->MUL/DIV on start at edge T0 (funct3[2] selects), MUL/DIV->DONE after last iteration, DONE->IDLE unconditionally next edge.
REQ-015 At T0 operands, funct3, rd_addr SHALL be captured; later input changes SHALL not affect the operation.
REQ-016 Signed operands SHALL be converted to magnitude at T0; final sign fix-up SHALL be applied on entry to DONE.
REQ-017 MUL path SHALL be shift-add, one bit per cycle, 32 iterations at edges T1..T32, 64-bit product; DONE entered at T33.
REQ-018 MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits with signed*signed, signed*unsigned, unsigned*unsigned semantics.
REQ-019 DIV path SHALL be restoring division, 32 iterations at T1..T32; DONE entered at T33.
REQ-020 Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A) (DIV/REM only).
REQ-021 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = A (all div ops).
REQ-022 Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000, remainder 0.
REQ-023 done SHALL be high for exactly the single cycle in DONE; busy low from the edge leaving DONE.
REQ-024 result and wb_addr SHALL hold their values after DONE until the next accepted start.
REQ-025 start while busy (MUL, DIV, DONE) SHALL be ignored, not queued.
REQ-026 Back-to-back: start high in the cycle after done SHALL be accepted (IDLE at that edge).

Reset
REQ-027 Reset assertion SHALL immediately force IDLE, busy=0, done=0, wb_en=0, result=0, wb_addr=0, clear datapath registers.
REQ-028 Reset mid-operation SHALL abort it with no write-back; first start after release SHALL be accepted normally.

Configuration
REQ-029 Macro MULDIV_FAST_SPECIAL_EN defined: divide-by-zero and signed overflow SHALL bypass iteration, DONE entered at T1.
REQ-030 Macro undefined: those cases SHALL run the full 32 iterations (DONE at T33) with identical results per REQ-021/022.

Verification
REQ-031 MUL A=7, B=0xFFFFFFFD -> done at T33, result 0xFFFFFFEB, wb_en=1 with wb_addr=rd_addr.
REQ-032 MULH A=0x80000000, B=0x80000000 -> result 0x40000000; MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 DIV A=-7 (0xFFFFFFF9), B=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-034 DIVU A=5, B=0 -> 0xFFFFFFFF, REMU -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; done at T1 with macro, T33 without.
REQ-035 Start pulsed at T5 during a busy op, rd_addr=0 op -> second start ignored; rd_addr=0 gives done=1, wb_en=0.
REQ-036 reset low at T10 of a DIV -> busy/done/result 0 immediately, no wb_en; start after release -> correct result at T33.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies by one-bit-per-cycle shift-add and divides by restoring division.
// Both paths run on operand magnitudes and fix up the result sign on the way
// into DONE. Normal operations finish 33 edges after the accepting edge.
// Optional macro MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow
// skip the iterations and reach DONE on the first edge after acceptance.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic [4:0]       rd_addr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       wb_addr_o,
  output logic             wb_en_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   b_q;        // multiplicand (MUL) or divisor (DIV) magnitude
  logic [2*WIDTH-1:0] acc_q;      // {product} or {remainder, quotient}
  logic [5:0]         cnt_q;
  logic               neg_q;      // negate product / quotient on fix-up
  logic               rem_neg_q;  // negate remainder on fix-up
  logic [WIDTH-1:0]   result_q;
  logic [4:0]         wb_addr_q;
  logic               busy_q;
  logic               done_q;

  logic               is_div, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_rem_sh, div_trial;
  logic [2*WIDTH-1:0] mul_acc_d, div_acc_d, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_result;

  // Operand decode on the raw inputs: signedness, magnitudes, special cases.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    is_div   = funct3_i[2];
    a_neg    = 1'b0;
    b_neg    = 1'b0;
    if (is_div) begin
      a_neg = ~funct3_i[0] & rs1_data_i[WIDTH-1];
      b_neg = ~funct3_i[0] & rs2_data_i[WIDTH-1];
    end else begin
      a_neg = (funct3_i[1:0] == 2'b01 || funct3_i[1:0] == 2'b10) & rs1_data_i[WIDTH-1];
      b_neg = (funct3_i[1:0] == 2'b01) & rs2_data_i[WIDTH-1];
    end
    mag_a    = a_neg ? -rs1_data_i : rs1_data_i;
    mag_b    = b_neg ? -rs2_data_i : rs2_data_i;
    div_zero = (rs2_data_i == '0);
    div_ovf  = ~funct3_i[0] && (rs1_data_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
               (rs2_data_i == {WIDTH{1'b1}});
  end

  // One shift-add step, one restoring-division step, and the sign fix-up.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_acc_d  = {mul_sum, acc_q[WIDTH-1:1]};
    div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial  = div_rem_sh - {1'b0, b_q};
    div_acc_d  = div_trial[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod_fix   = neg_q ? -acc_q : acc_q;
    quo_fix    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix    = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (op_q[2]) begin
      fix_result = op_q[1] ? rem_fix : quo_fix;
    end else begin
      fix_result = (op_q[1:0] == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM and datapath registers with registered busy/done/result.
  // NOTE: the datapath registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      wb_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q      <= funct3_i;
            wb_addr_q <= rd_addr_i;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            neg_q     <= (a_neg ^ b_neg) & ~(is_div & div_zero);
            rem_neg_q <= a_neg;
            if (is_div) begin
              state_q <= S_DIV;
              b_q     <= mag_b;
              acc_q   <= {{WIDTH{1'b0}}, mag_a};
`ifdef MULDIV_FAST_SPECIAL_EN
              if (div_zero || div_ovf) begin
                cnt_q <= 6'(WIDTH);
                acc_q <= div_zero ? {mag_a, {WIDTH{1'b1}}}
                                  : {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
              end
`endif
            end else begin
              state_q <= S_MUL;
              b_q     <= mag_a;
              acc_q   <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        S_MUL, S_DIV: begin
          if (cnt_q == 6'(WIDTH)) begin
            result_q <= fix_result;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            acc_q <= (state_q == S_MUL) ? mul_acc_d : div_acc_d;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // div_ovf only matters to the fast path; keep it referenced in every build.
  logic unused_ovf;
  assign unused_ovf = div_ovf;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign wb_addr_o = wb_addr_q;
  assign wb_en_o   = done_q && (wb_addr_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                         F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
  localparam int OP_LAT = 33;
`ifdef MULDIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [4:0]  rd;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd = '0;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  wb_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .funct3_i(funct3),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .rd_addr_i(rd),
    .busy_o(busy), .done_o(done), .result_o(result),
    .wb_addr_o(wb_addr), .wb_en_o(wb_en)
  );

  // Counts edges until done is seen (sampled 1ns after each edge); -1 on timeout.
  task automatic wait_done(input int max_cycles, output int n);
    n = -1;
    for (int i = 1; i <= max_cycles && n < 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) n = i;
    end
  endtask

  // Issues one op, scrambles inputs after acceptance, returns what was observed.
  task automatic run_op(input vec_t v, output int lat, output logic [31:0] res,
                        output logic wbe, output logic [4:0] wba, output logic tail_ok);
    @(negedge clk);
    funct3 = v.f; rs1 = v.a; rs2 = v.b; rd = v.rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~v.f; rs1 = ~v.a; rs2 = v.b ^ 32'h5A5A_A5A5; rd = ~v.rd;
    wait_done(40, lat);
    res = result; wbe = wb_en; wba = wb_addr;
    @(posedge clk); #1;
    tail_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, wb_en} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, wb_en}); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    total++; if (wb_addr !== 5'h0) begin bad++; $display("FAIL reset_wb_addr: got %h want 0", wb_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic run_table(input string tag, input vec_t v[], input int n);
    int lat; logic [31:0] res; logic wbe; logic [4:0] wba; logic tail_ok;
    for (int i = 0; i < n; i++) begin
      run_op(v[i], lat, res, wbe, wba, tail_ok);
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL %s[%0d] latency: got %0d want %0d", tag, i, lat, v[i].lat); end
      total++; if (res !== v[i].exp) begin bad++; $display("FAIL %s[%0d] result: got %h want %h", tag, i, res, v[i].exp); end
      total++; if (wbe !== (v[i].rd != 5'd0)) begin bad++; $display("FAIL %s[%0d] wb_en: got %b want %b", tag, i, wbe, v[i].rd != 5'd0); end
      total++; if (wba !== v[i].rd) begin bad++; $display("FAIL %s[%0d] wb_addr: got %h want %h", tag, i, wba, v[i].rd); end
      total++; if (tail_ok !== 1'b1) begin bad++; $display("FAIL %s[%0d] done_pulse: got busy=%b done=%b want 0 0", tag, i, busy, done); end
    end
  endtask

  task automatic test_mul();
    vec_t v[] = new[7];
    v[0] = '{F_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd5,  OP_LAT};
    v[1] = '{F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5'd6,  OP_LAT};
    v[2] = '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd7,  OP_LAT};
    v[3] = '{F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 5'd8,  OP_LAT};
    v[4] = '{F_MULHSU, 32'd2,         32'h8000_0000, 32'h0000_0001, 5'd10, OP_LAT};
    v[5] = '{F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5'd9,  OP_LAT};
    v[6] = '{F_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 5'd31, OP_LAT};
    run_table("mul", v, 7);
  endtask

  task automatic test_div();
    vec_t v[] = new[7];
    v[0] = '{F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'd1,  OP_LAT};
    v[1] = '{F_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'd2,  OP_LAT};
    v[2] = '{F_DIVU, 32'd100,       32'd7,         32'd14,        5'd3,  OP_LAT};
    v[3] = '{F_REMU, 32'd100,       32'd7,         32'd2,         5'd4,  OP_LAT};
    v[4] = '{F_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 5'd11, OP_LAT};
    v[5] = '{F_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         5'd12, OP_LAT};
    v[6] = '{F_DIVU, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 5'd13, OP_LAT};
    run_table("div", v, 7);
  endtask

  task automatic test_special();
    vec_t v[] = new[7];
    v[0] = '{F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd14, SPECIAL_LAT};
    v[1] = '{F_REMU, 32'd5,         32'd0,         32'd5,         5'd15, SPECIAL_LAT};
    v[2] = '{F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd16, SPECIAL_LAT};
    v[3] = '{F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd17, SPECIAL_LAT};
    v[4] = '{F_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 5'd18, SPECIAL_LAT};
    v[5] = '{F_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 5'd19, SPECIAL_LAT};
    v[6] = '{F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd20, OP_LAT};
    run_table("special", v, 7);
  endtask

  task automatic test_hold();
    vec_t v[] = new[1];
    v[0] = '{F_DIVU, 32'd1000, 32'd3, 32'd333, 5'd21, OP_LAT};
    run_table("hold_op", v, 1);
    repeat (3) @(posedge clk);
    #1;
    total++; if (result !== 32'd333) begin bad++; $display("FAIL hold_result: got %h want %h", result, 32'd333); end
    total++; if (wb_addr !== 5'd21) begin bad++; $display("FAIL hold_wb_addr: got %h want %h", wb_addr, 5'd21); end
    total++; if ({busy, done, wb_en} !== 3'b000) begin bad++; $display("FAIL hold_ctrl: got %b want 000", {busy, done, wb_en}); end
  endtask

  task automatic test_busy_ignore();
    int n, n2;
    @(negedge clk);
    funct3 = F_MUL; rs1 = 32'd3; rs2 = 32'd4; rd = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    funct3 = F_DIVU; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy: got %b want 1", busy); end
    wait_done(40, n);
    total++; if (n < 0 || n + 5 != OP_LAT) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", (n < 0) ? n : n + 5, OP_LAT); end
    total++; if (result !== 32'd12) begin bad++; $display("FAIL ignore_result: got %h want %h", result, 32'd12); end
    total++; if ({done, wb_en} !== 2'b10) begin bad++; $display("FAIL ignore_rd0_wb: got done,wb_en=%b want 10", {done, wb_en}); end
    total++; if (wb_addr !== 5'd0) begin bad++; $display("FAIL ignore_wb_addr: got %h want 0", wb_addr); end
    wait_done(40, n2);
    total++; if (n2 !== -1) begin bad++; $display("FAIL ignore_not_queued: got done after %0d cycles want none", n2); end
  endtask

  task automatic test_back_to_back();
    vec_t v[] = new[3];
    v[0] = '{F_MUL,  32'd9,         32'd9,  32'd81,        5'd22, OP_LAT};
    v[1] = '{F_REM,  32'hFFFF_FFF9, 32'd2,  32'hFFFF_FFFF, 5'd23, OP_LAT};
    v[2] = '{F_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 5'd24, OP_LAT};
    run_table("b2b", v, 3);
  endtask

  task automatic test_reset_mid_op();
    vec_t v[] = new[1];
    int n;
    @(negedge clk);
    funct3 = F_DIV; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; rd = 5'd25; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, wb_en} !== 3'b000) begin bad++; $display("FAIL midrst_ctrl: got %b want 000", {busy, done, wb_en}); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL midrst_result: got %h want 0", result); end
    total++; if (wb_addr !== 5'h0) begin bad++; $display("FAIL midrst_wb_addr: got %h want 0", wb_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_done(40, n);
    total++; if (n !== -1) begin bad++; $display("FAIL midrst_no_wb: got done after %0d cycles want none", n); end
    v[0] = '{F_DIVU, 32'd100, 32'd7, 32'd14, 5'd26, OP_LAT};
    run_table("midrst_after", v, 1);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_hold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
